input_debouncer: RTL
====================

// Module: input_debouncer
//
// PURPOSE
// Synchronises and debounces one asynchronous level input (push-button,
// external reset pin, jumper) into a clean, glitch-free level in the clk
// domain, with one-cycle edge strobes. Sits directly upstream of
// power_on_reset, which consumes signal_out as its debounced external reset
// and ties rst to 1'b0. Also used for user buttons feeding control logic.
//
// PARAMETERS
// BITS         8     stability counter width; a change needs 2**BITS consecutive agreeing samples
// SYNC_STAGES  2     synchroniser flops on signal_in, legal range >= 2
// RESET_VALUE  1'b1  value of signal_out and all sync flops at reset/power-up (idle level of an active-low pin)
//
// PORTS
// clk         in   1  system clock
// rst         in   1  synchronous, active-high reset
// signal_in   in   1  raw asynchronous input
// signal_out  out  1  debounced level
// rise        out  1  one-cycle pulse in the cycle signal_out goes 0->1
// fall        out  1  one-cycle pulse in the cycle signal_out goes 1->0
// busy        out  1  high while a candidate change is being counted (cnt != 0)
//
// BEHAVIOUR
// - Reset (rst=1 at posedge): sync chain <= all RESET_VALUE, cnt <= 0,
//   signal_out <= RESET_VALUE, rise=fall=0, busy=0.
// - Power-up: every register carries an initial value equal to its reset
//   value; the block is correct with rst tied 1'b0 (power_on_reset case).
// - Synchroniser: SYNC_STAGES-deep flop chain; s = last stage. Nothing else
//   samples signal_in directly.
// - Per posedge, rst=0:
//   * s == signal_out: cnt <= 0 (any bounce restarts the count).
//   * s != signal_out, cnt != 2**BITS-1: cnt <= cnt+1.
//   * s != signal_out, cnt == 2**BITS-1: signal_out <= s, cnt <= 0, rise<=s, fall<=!s.
//   * rise/fall are registered, high exactly one cycle, coincident with the
//     new signal_out value; never both high; 0 in every other cycle.
// - cnt is BITS wide, never wraps (cleared on commit or mismatch end).
// - Latency: a clean step on signal_in appears on signal_out
//   SYNC_STAGES + 2**BITS clock edges later.
// - Glitch rejection: a deviation of s lasting < 2**BITS cycles never
//   changes signal_out and produces no strobe.
// - busy = (cnt != 0), combinational from cnt.
// - rst asserted mid-count: count discarded, outputs return to reset values
//   on that edge; after release signal_out follows the usual rule (an input
//   held at !RESET_VALUE re-qualifies after the full latency).
// - Input toggling every cycle: signal_out holds indefinitely.
//
// TESTING  (BITS=3, SYNC_STAGES=2, RESET_VALUE=1 unless noted)
// 1 Reset: rst=1 for 2 cycles, signal_in=0 -> signal_out=1, rise=fall=busy=0.
// 2 Clean step: signal_in 1->0 before edge 1 -> signal_out=0 after edge 10,
//   fall=1 exactly that cycle only, busy high after edges 3..9.
// 3 Glitch: signal_in low for 7 cycles then high -> signal_out stays 1, no strobes, busy returns 0.
// 4 Bounce then settle: 3 low / 2 high / 10 low -> one fall pulse, 10 edges after the final low began.
// 5 Release: from signal_out=0, signal_in->1 -> rise pulse after 10 edges; rise&fall never both 1.
// 6 No-reset power-up: rst held 0, signal_in=1 from t0 -> signal_out=1 with no strobes;
//   rst pulsed at cnt=5 -> cnt=0, signal_out=1, re-qualification takes full 10 edges.

Source files
------------

// File: rtl/input_debouncer.sv
// Synchronises an asynchronous level input and only accepts a new level after
// 2**BITS consecutive agreeing samples, with one-cycle rise/fall strobes.
module input_debouncer #(
  parameter int   BITS        = 8,
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic signal_in,
  output logic signal_out,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam logic [BITS-1:0] CNT_MAX = '1;
  localparam logic [BITS-1:0] CNT_ONE = BITS'(1);

  // Declaration initialisers give correct power-up state when rst is tied low.
  logic [SYNC_STAGES-1:0] sync_reg = {SYNC_STAGES{RESET_VALUE}};
  logic [BITS-1:0]        cnt_reg  = '0;
  logic                   out_reg  = RESET_VALUE;
  logic                   rise_reg = 1'b0;
  logic                   fall_reg = 1'b0;
  logic                   s;

  assign s = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= {SYNC_STAGES{RESET_VALUE}};
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], signal_in};
    end
  end

  // Any disagreement-free sample restarts the count; a full run commits.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg  <= '0;
      out_reg  <= RESET_VALUE;
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
    end else begin
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
      if (s == out_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg != CNT_MAX) begin
        cnt_reg <= cnt_reg + CNT_ONE;
      end else begin
        cnt_reg  <= '0;
        out_reg  <= s;
        rise_reg <= s;
        fall_reg <= ~s;
      end
    end
  end

  assign signal_out = out_reg;
  assign rise       = rise_reg;
  assign fall       = fall_reg;
  assign busy       = (cnt_reg != '0);

endmodule
